// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: command codes, FSM states and
// the registered flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_XOR  = 4'd2,
        CMD_SLT  = 4'd3,
        CMD_AND  = 4'd4,
        CMD_NAND = 4'd5,
        CMD_NOR  = 4'd6,
        CMD_OR   = 4'd7,
        CMD_SLL  = 4'd8,
        CMD_SRL  = 4'd9,
        CMD_SRA  = 4'd10,
        CMD_MUL  = 4'd11
    } alu_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic carryout;
        logic zero;
        logic overflow;
    } alu_flags_t;

    function automatic logic is_mul(input logic [3:0] cmd);
        return cmd == CMD_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add unsigned multiplier: one iteration per clock, WIDTH
// iterations after start; done and product are valid during the last one.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   operandA,
    input  logic [WIDTH-1:0]   operandB,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               busy;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] acc_next;

    // Upper half accumulates the multiplicand while the multiplier drains
    // out of the lower half, one bit per iteration.
    always_comb begin
        partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {partial, acc[WIDTH-1:1]};
    end

    assign done    = busy && (count == LAST);
    assign product = acc_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= 1'b0;
            count <= '0;
            acc   <= '0;
            mcand <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
            acc   <= {{WIDTH{1'b0}}, operandB};
            mcand <= operandA;
        end else if (busy) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (count == LAST)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU: single-cycle arithmetic, logic and shift ops, plus an
// iterative WIDTH-cycle multiply, with registered result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state_q, state_d;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     add_sum, sub_diff;
    logic               add_ovf, sub_ovf;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    alu_flags_t         alu_flags;
    logic [WIDTH-1:0]   result_q;
    alu_flags_t         flags_q;

    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul(command);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .reset    (reset),
        .start    (mul_start),
        .operandA (operandA),
        .operandB (operandB),
        .done     (mul_done),
        .product  (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = !reset;
                if (accept)
                    state_d = is_mul(command) ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (mul_done)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                in_ready = !reset && out_ready;
                if (accept)
                    state_d = is_mul(command) ? ST_BUSY : ST_DONE;
                else if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // SUB and SLT share one A + ~B + 1 adder.
    always_comb begin
        add_sum  = {1'b0, operandA} + {1'b0, operandB};
        sub_diff = {1'b0, operandA} + {1'b0, ~operandB} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf  = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != operandA[WIDTH-1]);
        sub_ovf  = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                   (sub_diff[WIDTH-1] != operandA[WIDTH-1]);
        shamt    = operandB[SHW-1:0];
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (command)
            CMD_ADD: begin
                alu_res            = add_sum[WIDTH-1:0];
                alu_flags.carryout = add_sum[WIDTH];
                alu_flags.overflow = add_ovf;
            end
            CMD_SUB: begin
                alu_res            = sub_diff[WIDTH-1:0];
                alu_flags.carryout = sub_diff[WIDTH];
                alu_flags.overflow = sub_ovf;
            end
            CMD_SLT: begin
                alu_res            = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH-1] ^ sub_ovf};
                alu_flags.overflow = sub_ovf;
            end
            CMD_XOR:  alu_res = operandA ^ operandB;
            CMD_AND:  alu_res = operandA & operandB;
            CMD_NAND: alu_res = ~(operandA & operandB);
            CMD_NOR:  alu_res = ~(operandA | operandB);
            CMD_OR:   alu_res = operandA | operandB;
            CMD_SLL:  alu_res = operandA << shamt;
            CMD_SRL:  alu_res = operandA >> shamt;
            CMD_SRA:  alu_res = $signed(operandA) >>> shamt;
            default:  alu_res = '0;
        endcase
        alu_flags.zero = ~|alu_res;
    end

    // Output registers only load on a new result, so they hold while the
    // consumer stalls in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (accept && !is_mul(command)) begin
            result_q <= alu_res;
            flags_q  <= alu_flags;
        end else if (state_q == ST_BUSY && mul_done) begin
            result_q         <= mul_product[WIDTH-1:0];
            flags_q.carryout <= 1'b0;
            flags_q.zero     <= ~|mul_product[WIDTH-1:0];
            flags_q.overflow <= |mul_product[2*WIDTH-1:WIDTH];
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carryout  = flags_q.carryout;
    assign zero      = flags_q.zero;
    assign overflow  = flags_q.overflow;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: power of two, 8..64).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request present.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-006 SHALL have port command, input, 4, operation select.
REQ-007 SHALL have ports operandA and operandB, input, WIDTH, operands.
REQ-008 SHALL have port out_valid, output, 1, result registers hold a valid result.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-010 SHALL have port result, output, WIDTH, registered result.
REQ-011 SHALL have ports carryout, zero and overflow, output, 1 each, registered flags.

Function
REQ-012 Command encoding SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 SLL, 9 SRL, 10 SRA, 11 MUL, 12-15 reserved.
REQ-013 A request SHALL be accepted on a rising edge where in_valid and in_ready are both high; operands and command are captured at that edge.
REQ-014 in_ready SHALL be high in IDLE, and in DONE only when out_ready is high (drain and accept in the same cycle); low in BUSY.
REQ-015 The FSM SHALL have the states IDLE, BUSY and DONE. Transitions: IDLE/DONE -> DONE on accepting a non-MUL request; IDLE/DONE -> BUSY on accepting MUL; BUSY -> DONE after WIDTH iterations; DONE -> IDLE when out_ready is high and there is no new accept.
REQ-016 Non-MUL ops SHALL have latency 1: accepted at edge k, out_valid and result are valid after edge k.
REQ-017 MUL SHALL use radix-2 shift-add, one iteration per clock, with a 2*WIDTH-bit accumulator; when accepted at edge k, out_valid is high after edge k+WIDTH.
REQ-018 out_valid SHALL be high exactly in DONE; result and flags SHALL hold stable while out_valid is high and out_ready is low.
REQ-019 ADD/SUB: SUB is A + ~B + 1; carryout is the carry out of bit WIDTH-1; overflow is signed two's-complement overflow.
REQ-020 SLT: result is 1 if A < B signed (overflow-corrected sign of A-B), else 0; overflow reports the subtraction overflow; carryout is 0.
REQ-021 Shifts: the shift amount is operandB[log2(WIDTH)-1:0]; SRA replicates bit WIDTH-1; carryout and overflow are 0.
REQ-022 MUL: result is the low WIDTH bits of the unsigned product; overflow is 1 iff the upper WIDTH bits are nonzero; carryout is 0.
REQ-023 Logic ops: carryout and overflow are 0.
REQ-024 Reserved commands: result 0, zero 1, carryout 0, overflow 0, latency 1.
REQ-025 zero SHALL be 1 iff result is all zeros, for every command.
REQ-026 in_valid while in_ready is low SHALL be ignored; no request is queued.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, out_valid 0, result 0, carryout 0, zero 0 and overflow 0, including in the middle of a MUL, whose partial result is discarded.
REQ-028 in_ready SHALL be 0 while reset is high and 1 in the first cycle after deassertion.

Structure
REQ-029 Command codes and FSM state encodings SHALL live in the shared package alu_pkg.
REQ-030 The iterative multiplier SHALL be the sub-module alu_mul_iter (start, operands in; done, 2*WIDTH product out); all other datapath logic stays inline.

Verification
REQ-031 ADD, 0x7FFFFFFF + 0x00000001 -> after 1 cycle: result 0x80000000, overflow 1, carryout 0, zero 0.
REQ-032 SUB, 5 - 5 -> result 0, zero 1, carryout 1, overflow 0; SLT 0x80000000 vs 1 -> result 1.
REQ-033 MUL 0x00010000 * 0x00010000 -> out_valid exactly 32 cycles after accept, result 0, zero 1, overflow 1; in_ready low throughout BUSY.
REQ-034 SRA 0x80000000 by 0x24 (amount 4) -> result 0xF8000000; SRL -> 0x08000000.
REQ-035 Back-to-back ADD with out_ready held low for 3 cycles -> result stable, in_ready low; raise out_ready together with in_valid -> next result after 1 cycle with no bubble.
REQ-036 Reset asserted 10 cycles into a MUL -> out_valid 0 immediately; a following ADD 2+3 -> result 5 after 1 cycle.
